// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 2-to-4 decoder: steps sel through enabled positions
// with DWELL cycles of en high followed by BLANK cycles of en low.
module decoder_scan_sequencer #(
  parameter int DWELL = 8,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       start,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy,
  output logic       sweep_done
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [3:0] ABOVE_BASE = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      lo, nxt;
  logic            adv;

  // {found, index} of the lowest set bit
  function automatic logic [2:0] first_set(input logic [3:0] m);
    first_set = '0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) first_set = {1'b1, 2'(i)};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    lo      = first_set(mask);
    nxt     = first_set(mask & (ABOVE_BASE << sel_q));
    case (state_q)
      S_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if ((run || start) && lo[2]) begin
          state_d = S_DWELL;
          sel_d   = lo[1:0];
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          if (BLANK > 0) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            en_d    = 1'b0;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) adv = 1'b1;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Advance samples mask now; a cleared bit only matters from here on.
    if (adv) begin
      cnt_d = '0;
      if (nxt[2]) begin
        sel_d   = nxt[1:0];
        state_d = S_DWELL;
        en_d    = 1'b1;
        busy_d  = 1'b1;
      end else begin
        done_d = 1'b1;
        if (run && lo[2]) begin
          sel_d   = lo[1:0];
          state_d = S_DWELL;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule
